// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between icache refills and dcache refill/write-back.
// One line transaction at a time: IDLE grants, MEM waits for mem_ack, RESP pulses the owner's ack.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    RESP
  } state_t;

  state_t state;
  state_t next_state;

  logic owner_dc;
  logic last_gnt_dc;
  logic grant_dc;
  logic grant_ic;

  // On a tie the requester that did not win last time gets the port.
  assign grant_dc = dc_req && (!ic_req || !last_gnt_dc);
  assign grant_ic = ic_req && !grant_dc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_ic || grant_dc) next_state = MEM;
      MEM:     if (mem_ack) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Every output is a flop; acks default low so they can only pulse for the RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      ic_ack      <= 1'b0;
      dc_ack      <= 1'b0;
      ic_rdata    <= '0;
      dc_rdata    <= '0;
      owner_dc    <= 1'b0;
      last_gnt_dc <= 1'b0;
    end else begin
      ic_ack <= 1'b0;
      dc_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ic || grant_dc) begin
            mem_req     <= 1'b1;
            mem_addr    <= grant_dc ? dc_addr : ic_addr;
            mem_we      <= grant_dc && dc_we;
            mem_wdata   <= grant_dc ? dc_wdata : '0;
            owner_dc    <= grant_dc;
            last_gnt_dc <= grant_dc;
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (owner_dc) begin
              dc_rdata <= mem_rdata;
              dc_ack   <= 1'b1;
            end else begin
              ic_rdata <= mem_rdata;
              ic_ack   <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a latency-configurable memory responder plus a
// transaction-level model of grant order, ack timing and returned line data.
module tb_mem_arbiter;

  logic         clk;
  logic         reset;
  logic         ic_req;
  logic [31:0]  ic_addr;
  logic         ic_ack;
  logic [127:0] ic_rdata;
  logic         dc_req;
  logic         dc_we;
  logic [31:0]  dc_addr;
  logic [127:0] dc_wdata;
  logic         dc_ack;
  logic [127:0] dc_rdata;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  int errors = 0;
  int checks = 0;

  // Memory responder controls
  logic         zero_wait = 1'b0;
  logic         rand_lat  = 1'b1;
  int           mem_lat   = 0;
  int           wait_cnt  = 0;
  logic         force_en  = 1'b0;
  logic [127:0] force_data = '0;
  logic         mem_ack_r;
  logic [127:0] mem_rdata_r;

  // Reference: who won the previous grant (1 = dcache)
  logic last_dc = 1'b0;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1234_5678};
  endfunction

  mem_arbiter #(.ADDR_W(32), .LINE_W(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_ack    (ic_ack),
    .ic_rdata  (ic_rdata),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_ack    (dc_ack),
    .dc_rdata  (dc_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_ack   = zero_wait ? mem_req : mem_ack_r;
  assign mem_rdata = zero_wait ? line_of(mem_addr) : mem_rdata_r;

  // Memory: acks mem_lat cycles after it first sees mem_req (0 = first cycle)
  initial begin
    mem_ack_r   = 1'b0;
    mem_rdata_r = '0;
    forever begin
      @(negedge clk);
      mem_ack_r = 1'b0;
      if (mem_req && !zero_wait) begin
        if (wait_cnt >= mem_lat) begin
          mem_ack_r   = 1'b1;
          mem_rdata_r = force_en ? force_data : line_of(mem_addr);
          wait_cnt    = 0;
          if (rand_lat) mem_lat = $urandom_range(0, 4);
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic wait_ack(input int limit, output int ncyc, output logic got_ic, output logic got_dc);
    ncyc   = 0;
    got_ic = 1'b0;
    got_dc = 1'b0;
    while (ncyc < limit) begin
      @(negedge clk);
      ncyc++;
      if (ic_ack || dc_ack) begin
        got_ic = ic_ack;
        got_dc = dc_ack;
        return;
      end
    end
  endtask

  task automatic wait_mem_req(input int limit, output int ncyc);
    ncyc = 0;
    do begin
      @(negedge clk);
      ncyc++;
    end while (mem_req !== 1'b1 && ncyc < limit);
  endtask

  task automatic test_reset();
    int n;
    logic gi, gd;
    reset = 1'b1; ic_req = 1'b1; dc_req = 1'b1; dc_we = 1'b0;
    ic_addr = 32'h0000_1110; dc_addr = 32'h0000_2220; dc_wdata = '0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, ic_ack, dc_ack, mem_addr} !== 36'h0)
        $display("[TB] FAIL reset_outputs: req=%b we=%b ic_ack=%b dc_ack=%b addr=%h, required all 0", mem_req, mem_we, ic_ack, dc_ack, mem_addr);
    end
    checks++;
    if (ic_rdata !== '0 || dc_rdata !== '0 || mem_wdata !== '0)
      $display("[TB] FAIL reset_data: ic_rdata=%h dc_rdata=%h wdata=%h, required 0", ic_rdata, dc_rdata, mem_wdata);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== dc_addr) begin
      errors++;
      $display("[TB] FAIL first_tie_grant: req=%b addr=%h, required 1 / %h", mem_req, mem_addr, dc_addr);
    end
    last_dc = 1'b1;
    wait_ack(40, n, gi, gd);
    checks++;
    if (gd !== 1'b1 || gi !== 1'b0 || dc_rdata !== line_of(32'h0000_2220)) begin
      errors++;
      $display("[TB] FAIL reset_dc_txn: dc_ack=%b ic_ack=%b dc_rdata=%h, required 1/0/%h", gd, gi, dc_rdata, line_of(32'h0000_2220));
    end
    dc_req = 1'b0;
    wait_ack(40, n, gi, gd);
    last_dc = 1'b0;
    checks++;
    if (gi !== 1'b1 || gd !== 1'b0 || ic_rdata !== line_of(32'h0000_1110)) begin
      errors++;
      $display("[TB] FAIL reset_ic_txn: ic_ack=%b dc_ack=%b ic_rdata=%h, required 1/0/%h", gi, gd, ic_rdata, line_of(32'h0000_1110));
    end
    ic_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_ic_read();
    int n;
    logic gi, gd;
    force_data = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    force_en = 1'b1; rand_lat = 1'b0; mem_lat = 3;
    ic_addr = 32'h40; ic_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ic_read_request: req=%b addr=%h we=%b, required 1/00000040/0", mem_req, mem_addr, mem_we);
    end
    wait_ack(20, n, gi, gd);
    last_dc = 1'b0;
    checks++;
    if (gi !== 1'b1 || gd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ic_read_ack: ic_ack=%b dc_ack=%b, required 1/0", gi, gd);
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("[TB] FAIL ic_read_latency: %0d cycles after mem_req, required 4", n);
    end
    checks++;
    if (ic_rdata !== force_data) begin
      errors++;
      $display("[TB] FAIL ic_read_data: got %h, required %h", ic_rdata, force_data);
    end
    ic_req = 1'b0;
    @(negedge clk);
    checks++;
    if (ic_ack !== 1'b0 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ic_ack_pulse: ic_ack=%b mem_req=%b after ack cycle, required 0/0", ic_ack, mem_req);
    end
    force_en = 1'b0; rand_lat = 1'b1; mem_lat = $urandom_range(0, 4);
  endtask

  task automatic test_tie_fairness();
    int n;
    logic gi, gd, win_dc;
    logic [31:0] exp_addr;
    ic_addr = $urandom & 32'hFFFF_FFF0; dc_addr = $urandom & 32'hFFFF_FFF0;
    dc_we = $urandom_range(0, 1); dc_wdata = {$urandom, $urandom, $urandom, $urandom};
    ic_req = 1'b1; dc_req = 1'b1;
    for (int r = 0; r < 6; r++) begin
      win_dc = !last_dc;
      exp_addr = win_dc ? dc_addr : ic_addr;
      wait_mem_req(10, n);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== exp_addr || mem_we !== (win_dc && dc_we)) begin
        errors++;
        $display("[TB] FAIL tie_grant_%0d: req=%b addr=%h we=%b, required 1/%h/%b", r, mem_req, mem_addr, mem_we, exp_addr, win_dc && dc_we);
      end
      if (win_dc) begin
        checks++;
        if (mem_wdata !== dc_wdata) begin
          errors++;
          $display("[TB] FAIL tie_wdata_%0d: got %h, required %h", r, mem_wdata, dc_wdata);
        end
      end
      wait_ack(20, n, gi, gd);
      last_dc = win_dc;
      checks++;
      if (gd !== win_dc || gi !== !win_dc) begin
        errors++;
        $display("[TB] FAIL tie_ack_%0d: ic_ack=%b dc_ack=%b, required dc_ack=%b", r, gi, gd, win_dc);
      end
      if (!win_dc || !dc_we) begin
        checks++;
        if ((win_dc ? dc_rdata : ic_rdata) !== line_of(exp_addr)) begin
          errors++;
          $display("[TB] FAIL tie_rdata_%0d: got %h, required %h", r, win_dc ? dc_rdata : ic_rdata, line_of(exp_addr));
        end
      end
      if (win_dc) begin
        dc_addr = $urandom & 32'hFFFF_FFF0; dc_we = $urandom_range(0, 1);
        dc_wdata = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        ic_addr = $urandom & 32'hFFFF_FFF0;
      end
    end
    ic_req = 1'b0; dc_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_dc_writeback();
    int n;
    logic gi, gd;
    logic [127:0] ic_before;
    ic_before = ic_rdata;
    dc_we = 1'b1; dc_addr = 32'h100; dc_wdata = {4{32'hDEAD_BEEF}}; dc_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== {4{32'hDEAD_BEEF}}) begin
      errors++;
      $display("[TB] FAIL wb_request: req=%b we=%b addr=%h wdata=%h, required 1/1/00000100/deadbeef x4", mem_req, mem_we, mem_addr, mem_wdata);
    end
    wait_ack(20, n, gi, gd);
    last_dc = 1'b1;
    checks++;
    if (gd !== 1'b1 || gi !== 1'b0 || ic_rdata !== ic_before) begin
      errors++;
      $display("[TB] FAIL wb_ack: dc_ack=%b ic_ack=%b ic_rdata=%h, required 1/0/%h", gd, gi, ic_rdata, ic_before);
    end
    dc_req = 1'b0; dc_we = 1'b0;
    @(negedge clk);
    checks++;
    if (dc_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wb_ack_pulse: dc_ack=%b one cycle later, required 0", dc_ack);
    end
  endtask

  task automatic test_zero_wait();
    int n;
    logic gi, gd;
    zero_wait = 1'b1;
    ic_addr = 32'h200; ic_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(10, n, gi, gd);
      checks++;
      if (gi !== 1'b1 || n != (k == 0 ? 2 : 3)) begin
        errors++;
        $display("[TB] FAIL zero_wait_ack_%0d: ic_ack=%b after %0d cycles, required 1 after %0d", k, gi, n, k == 0 ? 2 : 3);
      end
      checks++;
      if (ic_rdata !== line_of(32'h200)) begin
        errors++;
        $display("[TB] FAIL zero_wait_data_%0d: got %h, required %h", k, ic_rdata, line_of(32'h200));
      end
    end
    last_dc = 1'b0;
    ic_req = 1'b0;
    @(negedge clk);
    zero_wait = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    logic gi, gd;
    rand_lat = 1'b0; mem_lat = 4;
    ic_addr = 32'h300; ic_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_setup: mem_req=%b, required 1", mem_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || ic_ack !== 1'b0 || dc_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_async: mem_req=%b ic_ack=%b dc_ack=%b before any edge, required 0", mem_req, ic_ack, dc_ack);
    end
    ic_req = 1'b0;
    last_dc = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    gi = 1'b0; gd = 1'b0;
    repeat (6) begin
      @(negedge clk);
      gi = gi | ic_ack | mem_req;
      gd = gd | dc_ack;
    end
    checks++;
    if (gi !== 1'b0 || gd !== 1'b0 || ic_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset_abandon: stray ic_ack/mem_req=%b dc_ack=%b ic_rdata=%h, required 0/0/0", gi, gd, ic_rdata);
    end
    rand_lat = 1'b1; mem_lat = $urandom_range(0, 4);
    ic_addr = 32'h80; ic_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_request: req=%b addr=%h we=%b, required 1/00000080/0", mem_req, mem_addr, mem_we);
    end
    wait_ack(20, n, gi, gd);
    checks++;
    if (gi !== 1'b1 || gd !== 1'b0 || ic_rdata !== line_of(32'h80)) begin
      errors++;
      $display("[TB] FAIL post_reset_read: ic_ack=%b dc_ack=%b ic_rdata=%h, required 1/0/%h", gi, gd, ic_rdata, line_of(32'h80));
    end
    ic_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
    ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    mem_lat = $urandom_range(0, 4);
    test_reset();
    test_single_ic_read();
    test_tie_fairness();
    test_dc_writeback();
    test_zero_wait();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
